// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the register-file writeback queue
package wb_pkg;

  localparam int REG_COUNT = 16;
  localparam int ADDR_W    = $clog2(REG_COUNT);
  localparam int DATA_W    = 32;
  localparam int PC_REG    = 15;

  // One pending register write: destination and value.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Result of a forwarding lookup.
  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } fwd_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order queue of pending writes with all slots visible for forwarding
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  wb_entry_t                  push_entry,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic [$clog2(DEPTH):0]     count,
  output wb_entry_t [DEPTH-1:0]      entries,
  output logic [DEPTH-1:0]           valid,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr
);

  logic [$clog2(DEPTH)-1:0] wr_ptr;

  assign head = entries[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries <= '0;
      valid   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else if (flush) begin
      valid   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_entry;
        valid[wr_ptr]   <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - arbitrates ALU/load results, retires them to the register file, forwards pending values
module regfile_writeback_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4,
  parameter int PC_REG = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     pc_redir_valid,
  output logic [DATA_W-1:0]        pc_redir_data,
  input  logic [ADDR_W-1:0]        fwd_addr1,
  output logic                     fwd_hit1,
  output logic [DATA_W-1:0]        fwd_data1,
  input  logic [ADDR_W-1:0]        fwd_addr2,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   pending_cnt
);

  import wb_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);

  wb_entry_t                push_entry;
  wb_entry_t                head;
  wb_entry_t [DEPTH-1:0]    q_entries;
  logic [DEPTH-1:0]         q_valid;
  logic [PTR_W-1:0]         rd_ptr;
  logic                     full;
  logic                     push;
  logic                     pop;
  fwd_t                     fwd1;
  fwd_t                     fwd2;

  // Loads win arbitration; nothing is accepted in reset, while full, or in a flush cycle.
  assign full       = (pending_cnt == ($clog2(DEPTH)+1)'(DEPTH));
  assign ld_ready   = rst_n && !full && !flush;
  assign alu_ready  = rst_n && !full && !flush && !ld_valid;
  assign push       = (ld_valid && ld_ready) || (alu_valid && alu_ready);
  assign push_entry = (ld_valid && ld_ready) ? wb_entry_t'{addr: ld_addr, data: ld_data}
                                             : wb_entry_t'{addr: alu_addr, data: alu_data};
  assign pop        = (pending_cnt != '0) && !flush;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (pending_cnt),
    .entries    (q_entries),
    .valid      (q_valid),
    .rd_ptr     (rd_ptr)
  );

  // Retire stage: the popped head becomes a one-cycle register write or a PC redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we          <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      pc_redir_valid <= 1'b0;
      pc_redir_data  <= '0;
    end else if (pop) begin
      if (head.addr == PC_ADDR) begin
        rf_we          <= 1'b0;
        pc_redir_valid <= 1'b1;
        pc_redir_data  <= head.data;
      end else begin
        rf_we          <= 1'b1;
        pc_redir_valid <= 1'b0;
        rf_waddr       <= head.addr;
        rf_wdata       <= head.data;
      end
    end else begin
      rf_we          <= 1'b0;
      pc_redir_valid <= 1'b0;
    end
  end

  // Scan oldest to youngest so the last match wins; the retire stage is older than every queue slot.
  function automatic fwd_t lookup(input logic [ADDR_W-1:0] a);
    fwd_t             r;
    logic [PTR_W-1:0] idx;
    r = '0;
    if (a != PC_ADDR) begin
      if (rf_we && rf_waddr == a) begin
        r.hit  = 1'b1;
        r.data = rf_wdata;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr + PTR_W'(k);
        if (q_valid[idx] && q_entries[idx].addr == a) begin
          r.hit  = 1'b1;
          r.data = q_entries[idx].data;
        end
      end
    end
    return r;
  endfunction

  assign fwd1      = lookup(fwd_addr1);
  assign fwd2      = lookup(fwd_addr2);
  assign fwd_hit1  = fwd1.hit;
  assign fwd_data1 = fwd1.data;
  assign fwd_hit2  = fwd2.hit;
  assign fwd_data2 = fwd2.data;

endmodule
